// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM states, grant
// identifiers, transfer size codes and the address remap constants.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INST  = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } grant_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Upper halfword of the uncached alias and the physical window it maps to.
    localparam logic [15:0] BFAF_HI  = 16'hbfaf;
    localparam logic [15:0] REMAP_HI = 16'h1faf;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bus. The arbiter drives requests through the master
// modport; the memory returns completion and read data on the slave side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              mem_access;
    logic              mem_write;
    logic [1:0]        mem_size;
    logic [3:0]        mem_sel;
    logic [ADDR_W-1:0] mem_a;
    logic [ADDR_W-1:0] mem_st_data;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_data;

    modport master (
        output mem_access, mem_write, mem_size, mem_sel, mem_a, mem_st_data,
        input  mem_ready, mem_data
    );

    modport slave (
        input  mem_access, mem_write, mem_size, mem_sel, mem_a, mem_st_data,
        output mem_ready, mem_data
    );
endinterface

// File: rtl/mem_port_arbiter_size_dec.sv
// Byte-enable to transfer size decode for data requests. Full or empty masks
// mean a word, aligned halfword masks mean a halfword, anything else is
// treated as a byte access.
module mem_size_dec
    import mem_port_arbiter_pkg::*;
(
    input  logic [3:0] d_sel,
    output logic [1:0] mem_size
);

    // Pure lookup on the byte-enable pattern.
    always_comb begin
        mem_size = SIZE_BYTE;
        case (d_sel)
            4'b0000, 4'b1111: mem_size = SIZE_WORD;
            4'b0011, 4'b1100: mem_size = SIZE_HALF;
            default:          mem_size = SIZE_BYTE;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetches and load/stores onto one shared memory port.
// One transaction is outstanding at a time; ties alternate between the two
// requesters. A flushed data access is drained so its late completion is
// swallowed rather than reported to the pipeline.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int BFAF_REMAP = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [ADDR_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [3:0]        d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [ADDR_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [ADDR_W-1:0] d_rdata,
    input  logic              flush,
    output logic              stall_if,
    output logic              stall_mem,
    mem_port_arbiter_if.master mem
);

    state_t     state;
    grant_t     last_grant;
    logic       d_live;
    logic       pick_inst;
    logic [1:0] d_size;

    // Alias window remap applied to data addresses only.
    function automatic logic [ADDR_W-1:0] remap_addr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = a;
        if ((BFAF_REMAP != 0) && (a[ADDR_W-1 -: 16] == BFAF_HI))
            r[ADDR_W-1 -: 16] = REMAP_HI;
        return r;
    endfunction

    mem_size_dec u_size_dec (
        .d_sel    (d_sel),
        .mem_size (d_size)
    );

    // A data request being flushed this cycle is not a candidate; on a tie the
    // fetch wins unless it was the last one served.
    always_comb begin
        d_live    = d_req & ~flush;
        pick_inst = i_req & (~d_live | (last_grant == GNT_DATA));
    end

    // Completion is reported in the same cycle the memory signals it.
    always_comb begin
        i_ready   = (state == ST_INST) & mem.mem_ready;
        d_ready   = (state == ST_DATA) & mem.mem_ready;
        i_rdata   = mem.mem_data;
        d_rdata   = mem.mem_data;
        stall_if  = i_req & ~i_ready;
        stall_mem = d_req & ~flush & ~d_ready;
    end

    // Arbitration FSM; the port request fields are latched at grant and held
    // until the transfer completes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= ST_IDLE;
            last_grant      <= GNT_DATA;
            mem.mem_access  <= 1'b0;
            mem.mem_write   <= 1'b0;
            mem.mem_size    <= 2'b00;
            mem.mem_sel     <= 4'b0000;
            mem.mem_a       <= '0;
            mem.mem_st_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_inst) begin
                        state           <= ST_INST;
                        mem.mem_access  <= 1'b1;
                        mem.mem_write   <= 1'b0;
                        mem.mem_size    <= SIZE_WORD;
                        mem.mem_sel     <= 4'b1111;
                        mem.mem_a       <= i_addr;
                        mem.mem_st_data <= '0;
                    end else if (d_live) begin
                        state           <= ST_DATA;
                        mem.mem_access  <= 1'b1;
                        mem.mem_write   <= d_wr;
                        mem.mem_size    <= d_size;
                        mem.mem_sel     <= d_sel;
                        mem.mem_a       <= remap_addr(d_addr);
                        mem.mem_st_data <= d_wdata;
                    end
                end
                ST_INST: begin
                    if (mem.mem_ready) begin
                        state          <= ST_IDLE;
                        mem.mem_access <= 1'b0;
                        last_grant     <= GNT_INST;
                    end
                end
                ST_DATA: begin
                    if (mem.mem_ready) begin
                        state          <= ST_IDLE;
                        mem.mem_access <= 1'b0;
                        last_grant     <= GNT_DATA;
                    end else if (flush) begin
                        // The memory still owes a completion; wait it out.
                        state          <= ST_DRAIN;
                        mem.mem_access <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (mem.mem_ready)
                        state <= ST_IDLE;
                end
                default: begin
                    state          <= ST_IDLE;
                    mem.mem_access <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, remapped store, tie
// alternation, flush drain, reset abandonment and size decode.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req, d_req, d_wr, flush;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_sel;
    logic        i_ready, d_ready, stall_if, stall_mem;
    logic [31:0] i_rdata, d_rdata;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter_if #(.ADDR_W(32)) mem_if ();

    mem_port_arbiter #(.ADDR_W(32), .BFAF_REMAP(1)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_sel     (d_sel),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .flush     (flush),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .mem       (mem_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 2 ns past the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] sel_tab  [6];
    logic [1:0] size_tab [6];

    initial begin
        sel_tab  = '{4'b1100, 4'b0110, 4'b0011, 4'b0000, 4'b1000, 4'b0101};
        size_tab = '{2'b01,   2'b00,   2'b01,   2'b10,   2'b00,   2'b00};

        resetn = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; flush = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_sel = '0;
        mem_if.mem_ready = 1'b1; mem_if.mem_data = 32'h0;
        cyc(); cyc();

        // Reset state, with a stray mem_ready present
        check("rst_access", mem_if.mem_access, 1'b0);
        check("rst_write",  mem_if.mem_write,  1'b0);
        check("rst_a",      mem_if.mem_a,      32'h0);
        check("rst_sel",    mem_if.mem_sel,    4'h0);
        check("rst_size",   mem_if.mem_size,   2'b00);
        check("rst_stdata", mem_if.mem_st_data, 32'h0);
        check("rst_iready", i_ready, 1'b0);
        check("rst_dready", d_ready, 1'b0);

        // Lone fetch, memory answers 3 cycles after grant
        resetn = 1'b1; mem_if.mem_ready = 1'b0;
        i_req = 1'b1; i_addr = 32'hbfc00000;
        #1 check("f_stall_if", stall_if, 1'b1);
        cyc();
        check("f_access", mem_if.mem_access, 1'b1);
        check("f_a",      mem_if.mem_a, 32'hbfc00000);
        check("f_write",  mem_if.mem_write, 1'b0);
        check("f_sel",    mem_if.mem_sel, 4'hf);
        check("f_size",   mem_if.mem_size, 2'b10);
        check("f_noready", i_ready, 1'b0);
        cyc(); cyc();
        check("f_hold_a", mem_if.mem_a, 32'hbfc00000);
        cyc();
        mem_if.mem_ready = 1'b1; mem_if.mem_data = 32'h24010001;
        #1;
        check("f_iready", i_ready, 1'b1);
        check("f_rdata",  i_rdata, 32'h24010001);
        check("f_stall_done", stall_if, 1'b0);
        check("f_no_dready", d_ready, 1'b0);
        cyc();
        i_req = 1'b0; mem_if.mem_ready = 1'b0;
        #1;
        check("f_idle_access", mem_if.mem_access, 1'b0);
        check("f_idle_iready", i_ready, 1'b0);

        // Byte store into the remapped window
        d_req = 1'b1; d_wr = 1'b1; d_sel = 4'b0100; d_addr = 32'hbfaf8000; d_wdata = 32'hdeadbeef;
        #1 check("s_stall_mem", stall_mem, 1'b1);
        cyc();
        check("s_access", mem_if.mem_access, 1'b1);
        check("s_a",      mem_if.mem_a, 32'h1faf8000);
        check("s_size",   mem_if.mem_size, 2'b00);
        check("s_write",  mem_if.mem_write, 1'b1);
        check("s_sel",    mem_if.mem_sel, 4'b0100);
        check("s_stdata", mem_if.mem_st_data, 32'hdeadbeef);
        mem_if.mem_ready = 1'b1;
        #1;
        check("s_dready", d_ready, 1'b1);
        check("s_stall_done", stall_mem, 1'b0);
        cyc();
        d_req = 1'b0; d_wr = 1'b0; mem_if.mem_ready = 1'b0;
        #1 check("s_idle_access", mem_if.mem_access, 1'b0);

        // Tie right after reset: fetch first, then data, next tie fetch again
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        i_req = 1'b1; i_addr = 32'h00001000;
        d_req = 1'b1; d_sel = 4'hf; d_addr = 32'h00002000;
        cyc();
        check("t1_a", mem_if.mem_a, 32'h00001000);
        check("t1_write", mem_if.mem_write, 1'b0);
        mem_if.mem_ready = 1'b1;
        #1;
        check("t1_iready", i_ready, 1'b1);
        check("t1_dready", d_ready, 1'b0);
        cyc();
        i_req = 1'b0; mem_if.mem_ready = 1'b0;
        cyc();
        check("t2_a", mem_if.mem_a, 32'h00002000);
        check("t2_size", mem_if.mem_size, 2'b10);
        mem_if.mem_ready = 1'b1;
        #1 check("t2_dready", d_ready, 1'b1);
        cyc();
        mem_if.mem_ready = 1'b0;
        i_req = 1'b1; i_addr = 32'h00003000; d_addr = 32'h00004000;
        cyc();
        check("t3_a", mem_if.mem_a, 32'h00003000);
        mem_if.mem_ready = 1'b1;
        cyc();
        i_req = 1'b0; mem_if.mem_ready = 1'b0;
        cyc();
        check("t4_a", mem_if.mem_a, 32'h00004000);
        mem_if.mem_ready = 1'b1;
        cyc();
        d_req = 1'b0; mem_if.mem_ready = 1'b0;

        // Flush mid-load; the late completion is swallowed
        d_req = 1'b1; d_sel = 4'hf; d_addr = 32'h00005000;
        cyc();
        check("fl_access", mem_if.mem_access, 1'b1);
        flush = 1'b1;
        #1;
        check("fl_stall_mem", stall_mem, 1'b0);
        check("fl_dready", d_ready, 1'b0);
        cyc();
        flush = 1'b0; d_req = 1'b0;
        i_req = 1'b1; i_addr = 32'h00006000;
        #1;
        check("dr_access", mem_if.mem_access, 1'b0);
        cyc();
        check("dr_access2", mem_if.mem_access, 1'b0);
        check("dr_stall_if", stall_if, 1'b1);
        mem_if.mem_ready = 1'b1;
        #1;
        check("dr_dready", d_ready, 1'b0);
        check("dr_iready", i_ready, 1'b0);
        cyc();
        mem_if.mem_ready = 1'b0;
        #1 check("dr_idle_access", mem_if.mem_access, 1'b0);
        cyc();
        check("dr_after_access", mem_if.mem_access, 1'b1);
        check("dr_after_a", mem_if.mem_a, 32'h00006000);

        // Reset during the fetch, then a stale completion
        flush = 1'b1;
        cyc();
        check("fi_access", mem_if.mem_access, 1'b1);
        flush = 1'b0;
        resetn = 1'b0;
        cyc();
        check("rr_access", mem_if.mem_access, 1'b0);
        check("rr_a", mem_if.mem_a, 32'h0);
        resetn = 1'b1; i_req = 1'b0; mem_if.mem_ready = 1'b1;
        #1 check("rr_stale_iready", i_ready, 1'b0);
        cyc();
        check("rr_stale_access", mem_if.mem_access, 1'b0);
        check("rr_stale_iready2", i_ready, 1'b0);
        mem_if.mem_ready = 1'b0;

        // Flush blocks a data request in IDLE
        d_req = 1'b1; flush = 1'b1; d_addr = 32'h00008000;
        cyc();
        check("fidle_access", mem_if.mem_access, 1'b0);
        flush = 1'b0;

        // Flush coincident with completion still completes
        cyc();
        check("fc_access", mem_if.mem_access, 1'b1);
        flush = 1'b1; mem_if.mem_ready = 1'b1;
        #1 check("fc_dready", d_ready, 1'b1);
        cyc();
        flush = 1'b0; mem_if.mem_ready = 1'b0; d_req = 1'b0;
        #1 check("fc_idle_access", mem_if.mem_access, 1'b0);

        // Size decode sweep, non-aliased address passes unchanged
        d_addr = 32'hbfae1234;
        for (int k = 0; k < 6; k++) begin
            d_req = 1'b1; d_sel = sel_tab[k];
            cyc();
            check($sformatf("sz_size_%0d", k), mem_if.mem_size, size_tab[k]);
            check($sformatf("sz_sel_%0d", k), mem_if.mem_sel, sel_tab[k]);
            check($sformatf("sz_a_%0d", k), mem_if.mem_a, 32'hbfae1234);
            mem_if.mem_ready = 1'b1;
            #1 check($sformatf("sz_dready_%0d", k), d_ready, 1'b1);
            cyc();
            d_req = 1'b0; mem_if.mem_ready = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address and data width.
REQ-002 Parameter BFAF_REMAP, default 1, enables 0xbfaf->0x1faf upper-halfword address remap on data requests.
REQ-003 clk  in  1  clock; reset resetn, synchronous, active-low.
REQ-004 i_req  in  1  instruction fetch request; i_addr  in  32  fetch address.
REQ-005 i_ready  out  1  fetch done pulse; i_rdata  out  32  fetch data, valid with i_ready.
REQ-006 d_req  in  1  load/store request; d_wr  in  1  store; d_sel  in  4  byte enables; d_addr  in  32; d_wdata  in  32.
REQ-007 d_ready  out  1  load/store done pulse; d_rdata  out  32  load data, valid with d_ready.
REQ-008 flush  in  1  exception flush; cancels the pending data request.
REQ-009 mem_access  out  1; mem_write  out  1; mem_size  out  2; mem_sel  out  4; mem_a  out  32; mem_st_data  out  32  shared memory port request.
REQ-010 mem_ready  in  1  shared port completion pulse; mem_data  in  32  shared port read data.
REQ-011 stall_if  out  1; stall_mem  out  1  pipeline stall requests.

Function
REQ-012 FSM states IDLE, INST, DATA, DRAIN; one outstanding transaction maximum.
REQ-013 IDLE: when i_req or (d_req & ~flush) is high, latch the winner's address, write, sel and wdata and enter INST or DATA next cycle.
REQ-014 Both requests in the same IDLE cycle: grant the requester not granted last; last_grant register resets to DATA, so the first tie goes to INST.
REQ-015 INST/DATA: mem_access=1; mem_a, mem_write, mem_sel, mem_size and mem_st_data come from the latched values and stay stable until mem_ready.
REQ-016 INST grant: mem_write=0, mem_sel=4'b1111, mem_size=2'b10.
REQ-017 DATA grant mem_size from d_sel: 0000/1111->10; 0011/1100->01; one-hot->00; any other pattern->00.
REQ-018 DATA grant: if BFAF_REMAP and d_addr[31:16]==16'hbfaf, mem_a={16'h1faf,d_addr[15:0]}; otherwise d_addr unchanged.
REQ-019 mem_ready in INST: i_ready=1 and i_rdata=mem_data in the same cycle (combinational); state->IDLE; last_grant<=INST.
REQ-020 mem_ready in DATA: d_ready=1 and d_rdata=mem_data in the same cycle; state->IDLE; last_grant<=DATA.
REQ-021 flush in DATA without mem_ready: go to DRAIN and deassert mem_access.
REQ-022 DRAIN: wait for mem_ready, discard it (d_ready stays 0), then return to IDLE.
REQ-023 flush in DATA coincident with mem_ready: the transfer completes normally and d_ready=1.
REQ-024 flush in INST has no effect.
REQ-025 stall_if = i_req & ~i_ready.
REQ-026 stall_mem = d_req & ~flush & ~d_ready.
REQ-027 mem_ready in IDLE is ignored.
REQ-028 Requests are level-held by requesters until the matching ready; minimum latency is request to ready in 2 cycles (with mem_ready one cycle after grant).

Reset
REQ-029 resetn low at a clock edge: state=IDLE, last_grant=DATA, latches cleared; mem_access, mem_write, i_ready, d_ready =0; mem_a, mem_sel, mem_size, mem_st_data =0.
REQ-030 Reset mid-transaction abandons it; a later mem_ready is ignored per REQ-027.

Structure
REQ-031 State encoding, the grant enum and the 0xbfaf/0x1faf constants SHALL live in the shared define package.
REQ-032 The size decode SHALL be a sub-module, mem_size_dec (d_sel -> mem_size).

Verification
REQ-033 Lone fetch: i_req=1, i_addr=0xbfc00000, mem_ready 3 cycles after grant with mem_data=0x24010001 -> i_ready one cycle, i_rdata=0x24010001, mem_write=0, mem_sel=1111.
REQ-034 Byte store with remap: d_req=1, d_wr=1, d_sel=0100, d_addr=0xbfaf8000 -> mem_a=0x1faf8000, mem_size=00, mem_write=1, mem_sel=0100.
REQ-035 Tie after reset: i_req=d_req=1 together -> INST granted first, then DATA; the next tie grants INST again.
REQ-036 Flush mid-load: DATA active, flush pulse, mem_ready 2 cycles later -> state DRAIN then IDLE, d_ready never asserted, stall_mem=0 during flush.
REQ-037 Reset during INST, before mem_ready -> next cycle IDLE, mem_access=0; a stale mem_ready produces no i_ready.
REQ-038 Halfword load with d_sel=1100 -> mem_size=01; d_sel=0110 -> mem_size=00.
